mmio_hub: RTL and testbench

Parametrised memory-mapped I/O hub between the CPU data port and the board peripherals (LEDs, switches, SPART). It decodes a 16-word window at `BASE`, holds the LED register, and synchronises the switches with optional rising-edge capture. It gates SPART chip-select using the queue status, so the CPU cannot overrun TX or read an empty RX. Read data is registered and carries a valid strobe.

---
 rtl/mmio_hub.sv | 138 +++++++++++++
 tb/tb_mmio_hub.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_hub.sv
`default_nettype none
// ============================================================================
// mmio_hub : 16-word MMIO window (LED, switches, SPART gate, status).
// Optional SW_EDGE register enabled by macro MMIO_SW_EDGE_EN.  Rev 1.0
// ============================================================================
module mmio_hub #(
  parameter logic [15:0] BASE        = 16'hC000,
  parameter int          LED_W       = 10,
  parameter int          SW_W        = 10,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [15:0]       rdata,
  output logic              rdata_vld,
  output logic              hit,
  output logic [LED_W-1:0]  LEDR,
  input  logic [SW_W-1:0]   SW,
  output logic              io_cs_n,
  output logic              io_rw_n,
  output logic [1:0]        io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata,
  input  logic              tx_q_full,
  input  logic              rx_q_empty
);

  logic [15:0] offset;
  logic [3:0]  off;
  logic        in_win, wr, rd, spart_sel, spart_supp;
  logic [15:0] rd_mux;

  logic [LED_W-1:0]                  led_q, led_d;
  logic [SYNC_STAGES-1:0][SW_W-1:0]  sync_q, sync_d;
  logic [SW_W-1:0]                   sw_lvl;
  logic                              tx_drop_q, tx_drop_d, rx_under_q, rx_under_d;
  logic [15:0]                       rdata_q, rdata_d;
  logic                              rdata_vld_q, rdata_vld_d;

  assign offset = addr - BASE;
  assign off    = offset[3:0];
  assign in_win = (offset[15:4] == 12'd0);
  assign hit    = in_win & (we | re);
  // A simultaneous read is dropped in favour of the write.
  assign wr     = hit & we;
  assign rd     = hit & re & ~we;
  assign sw_lvl = sync_q[SYNC_STAGES-1];

  assign spart_sel  = hit & (off[3:2] == 2'b01);
  assign spart_supp = (off == 4'd4) & ((we & tx_q_full) | (~we & re & rx_q_empty));
  assign io_cs_n    = ~(spart_sel & ~spart_supp);
  assign io_rw_n    = ~we;
  assign io_addr    = addr[1:0];
  assign io_wdata   = wdata;

  assign LEDR      = led_q;
  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;

`ifdef MMIO_SW_EDGE_EN
  logic [SW_W-1:0] edge_q, edge_d, sw_prev_q, sw_prev_d;

  always_comb begin
    sw_prev_d = sw_lvl;
    edge_d    = edge_q;
    if (wr && off == 4'd2) edge_d = edge_d & ~wdata[SW_W-1:0];
    // Rising edges are OR-ed in last so a new edge beats a same-cycle clear.
    edge_d = edge_d | (sw_lvl & ~sw_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q    <= '0;
      sw_prev_q <= '0;
    end else begin
      edge_q    <= edge_d;
      sw_prev_q <= sw_prev_d;
    end
  end
`endif

  always_comb begin
    rd_mux = 16'd0;
    case (off)
      4'd0: rd_mux = 16'(led_q);
      4'd1: rd_mux = 16'(sw_lvl);
`ifdef MMIO_SW_EDGE_EN
      4'd2: rd_mux = 16'(edge_q);
`endif
      4'd4, 4'd5, 4'd6, 4'd7:
        rd_mux = (off == 4'd4 && rx_q_empty) ? 16'd0 : io_rdata;
      4'd8: rd_mux = {12'd0, rx_under_q, tx_drop_q, rx_q_empty, tx_q_full};
      default: rd_mux = 16'd0;
    endcase
  end

  always_comb begin
    led_d       = led_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], SW};
    tx_drop_d   = tx_drop_q;
    rx_under_d  = rx_under_q;
    rdata_d     = rdata_q;
    rdata_vld_d = rd;

    if (wr && off == 4'd0) led_d = wdata[LED_W-1:0];
    if (wr && off == 4'd8) begin
      if (wdata[2]) tx_drop_d  = 1'b0;
      if (wdata[3]) rx_under_d = 1'b0;
    end
    if (wr && off == 4'd4 && tx_q_full)  tx_drop_d  = 1'b1;
    if (rd && off == 4'd4 && rx_q_empty) rx_under_d = 1'b1;
    if (rd) rdata_d = rd_mux;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q       <= '0;
      sync_q      <= '0;
      tx_drop_q   <= 1'b0;
      rx_under_q  <= 1'b0;
      rdata_q     <= 16'd0;
      rdata_vld_q <= 1'b0;
    end else begin
      led_q       <= led_d;
      sync_q      <= sync_d;
      tx_drop_q   <= tx_drop_d;
      rx_under_q  <= rx_under_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_hub.sv
`default_nettype none
// ============================================================================
// tb_mmio_hub : scoreboard bench for mmio_hub (directed vectors).  Rev 1.0
// ============================================================================
module tb_mmio_hub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0, wdata = '0, io_rdata = '0;
  logic        we = 1'b0, re = 1'b0, tx_q_full = 1'b0, rx_q_empty = 1'b1;
  logic [9:0]  SW = '0;
  logic [15:0] rdata, io_wdata;
  logic        rdata_vld, hit, io_cs_n, io_rw_n;
  logic [9:0]  LEDR;
  logic [1:0]  io_addr;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  mmio_hub #(.BASE(16'hC000), .LED_W(10), .SW_W(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rdata_vld(rdata_vld), .hit(hit), .LEDR(LEDR), .SW(SW),
    .io_cs_n(io_cs_n), .io_rw_n(io_rw_n), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .tx_q_full(tx_q_full),
    .rx_q_empty(rx_q_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive just after the rising edge and hold until the next call.
  task automatic cyc(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    we = w; re = r; addr = a; wdata = d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic rd_exp(input logic [15:0] a, input logic [15:0] e);
    cyc(1'b0, 1'b1, a, 16'h0000);
    exp_q.push_back(e);
  endtask

  // Monitor: every presented read result must match the oldest expectation.
  always @(negedge clk) begin
    if (rdata_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_vld: rdata_vld=1 rdata=0x%04h, no read pending at %0t", rdata, $time);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset_LEDR", 16'(LEDR), 16'h0000);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_vld", 16'(rdata_vld), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // LED write then read back
    cyc(1'b1, 1'b0, 16'hC000, 16'h03FF);
    #2 chk("hit_led_wr", 16'(hit), 16'h0001);
    rd_exp(16'hC000, 16'h03FF);
    @(negedge clk);
    chk("LEDR_after_wr", 16'(LEDR), 16'h03FF);

    // Switch synchroniser
    idle();
    SW = 10'h005;
    idle();
    idle();
    rd_exp(16'hC001, 16'h0005);
`ifdef MMIO_SW_EDGE_EN
    rd_exp(16'hC002, 16'h0005);
    cyc(1'b1, 1'b0, 16'hC002, 16'h0001);
    rd_exp(16'hC002, 16'h0004);
`else
    rd_exp(16'hC002, 16'h0000);
`endif

    // TX overrun suppression and sticky status
    rx_q_empty = 1'b0;
    tx_q_full  = 1'b1;
    cyc(1'b1, 1'b0, 16'hC004, 16'h0041);
    #2 chk("tx_full_cs_n", 16'(io_cs_n), 16'h0001);
    rd_exp(16'hC008, 16'h0005);
    cyc(1'b1, 1'b0, 16'hC008, 16'h0004);
    rd_exp(16'hC008, 16'h0001);
    cyc(1'b1, 1'b0, 16'hC005, 16'h0077);
    #2 chk("baud_wr_cs_n", 16'(io_cs_n), 16'h0000);
    chk("baud_wr_rw_n", 16'(io_rw_n), 16'h0000);
    chk("baud_wr_wdata", io_wdata, 16'h0077);
    tx_q_full = 1'b0;

    // SPART read passes through, back-to-back with a status read
    io_rdata = 16'h005A;
    rd_exp(16'hC004, 16'h005A);
    #2 chk("rx_rd_cs_n", 16'(io_cs_n), 16'h0000);
    chk("rx_rd_rw_n", 16'(io_rw_n), 16'h0001);
    chk("rx_rd_io_addr", 16'(io_addr), 16'h0000);
    rd_exp(16'hC007, 16'h005A);
    #2 chk("reg7_io_addr", 16'(io_addr), 16'h0003);

    // RX underrun suppression
    rx_q_empty = 1'b1;
    rd_exp(16'hC004, 16'h0000);
    #2 chk("rx_empty_cs_n", 16'(io_cs_n), 16'h0001);
    rd_exp(16'hC008, 16'h000A);
    cyc(1'b1, 1'b0, 16'hC008, 16'h0008);
    rd_exp(16'hC008, 16'h0002);

    // Window boundaries
    cyc(1'b1, 1'b0, 16'hB000, 16'h0123);
    #2 chk("hit_B000", 16'(hit), 16'h0000);
    cyc(1'b0, 1'b1, 16'hD000, 16'h0000);
    #2 chk("hit_D000", 16'(hit), 16'h0000);
    cyc(1'b1, 1'b0, 16'hC010, 16'h0001);
    #2 chk("hit_C010", 16'(hit), 16'h0000);
    rd_exp(16'hC00F, 16'h0000);
    #2 chk("hit_C00F", 16'(hit), 16'h0001);
    chk("C00F_cs_n", 16'(io_cs_n), 16'h0001);
    @(negedge clk);
    chk("LEDR_unchanged", 16'(LEDR), 16'h03FF);

    // Simultaneous write and read: write wins, no read result
    cyc(1'b1, 1'b1, 16'hC000, 16'h000F);
    idle();
    @(negedge clk);
    chk("LEDR_we_re", 16'(LEDR), 16'h000F);
    rd_exp(16'hC000, 16'h000F);
    idle();
    idle();

    // Reset asserted while a read result is pending
    cyc(1'b0, 1'b1, 16'hC000, 16'h0000);
    #6;
    rst_n = 1'b0;
    re = 1'b0;
    @(negedge clk);
    chk("rst_LEDR", 16'(LEDR), 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_vld", 16'(rdata_vld), 16'h0000);
    chk("rst_cs_n", 16'(io_cs_n), 16'h0001);
    #2 rst_n = 1'b1;
    repeat (3) idle();
    @(negedge clk);
    chk("post_rst_LEDR", 16'(LEDR), 16'h0000);

    chk("pending_reads", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
